// File: rtl/dm_stage_pkg.sv
// dm_stage_pkg: shared definitions for the MEM-stage data memory.
//   size_e               access-size encoding carried on Size_M
//   DM_BASE_ADDR_DEFAULT default byte address of word 0
package dm_stage_pkg;

   typedef enum logic [1:0] {
      SZ_WORD = 2'b00,
      SZ_HALF = 2'b01,
      SZ_BYTE = 2'b10,
      SZ_RSVD = 2'b11
   } size_e;

   localparam logic [31:0] DM_BASE_ADDR_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/dm_store_merge.sv
// dm_store_merge: combinational store-data merge into an existing word.
//   old_word  [31:0] in   currently stored word
//   wdata     [31:0] in   right-justified store data
//   size      [1:0]  in   access size (size_e encoding)
//   lane      [1:0]  in   byte offset within the word
//   merged    [31:0] out  word after the store is applied
//   byte_mask [3:0]  out  little-endian byte lanes written (0 for reserved size)
module dm_store_merge
   import dm_stage_pkg::*;
(
   input  logic [31:0] old_word,
   input  logic [31:0] wdata,
   input  logic [1:0]  size,
   input  logic [1:0]  lane,
   output logic [31:0] merged,
   output logic [3:0]  byte_mask
);

   logic [31:0] rep_data;

   always_comb begin
      byte_mask = '0;
      rep_data  = wdata;
      case (size_e'(size))
         SZ_WORD: begin
            byte_mask = 4'b1111;
            rep_data  = wdata;
         end
         SZ_HALF: begin
            byte_mask = lane[1] ? 4'b1100 : 4'b0011;
            rep_data  = {2{wdata[15:0]}};
         end
         SZ_BYTE: begin
            byte_mask = 4'b0001 << lane;
            rep_data  = {4{wdata[7:0]}};
         end
         default: begin
            byte_mask = '0;
            rep_data  = wdata;
         end
      endcase
   end

   // Data is replicated across lanes so each byte just picks old or new.
   always_comb begin
      merged = old_word;
      for (int unsigned i = 0; i < 4; i++) begin
         if (byte_mask[i]) merged[8*i +: 8] = rep_data[8*i +: 8];
      end
   end

endmodule

// File: rtl/dm_stage.sv
// dm_stage: MEM-stage data memory, word-organised, little-endian lanes.
// Stores commit on posedge clk; reads are combinational raw words.
// Optional macro DM_DISPLAY_EN: print each committed store.
//   clk          in   system clock
//   reset        in   synchronous active-high reset, clears all words
//   MemWrite_M   in   store request
//   MemRead_M    in   load request (error check only)
//   Size_M [1:0] in   00 word, 01 half, 10 byte, 11 reserved
//   ALUOut_M     in   byte address
//   WriteData_M  in   right-justified store data
//   pc_M         in   PC of MEM-stage instruction (debug print only)
//   ReadData_M   out  raw word at addressed index, 0 when out of range
//   AddrErr_M    out  misaligned / out-of-range / reserved-size access
module dm_stage
   import dm_stage_pkg::*;
#(
   parameter int unsigned  ADDR_WIDTH = 10,
   parameter logic [31:0]  BASE_ADDR  = DM_BASE_ADDR_DEFAULT
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite_M,
   input  logic        MemRead_M,
   input  logic [1:0]  Size_M,
   input  logic [31:0] ALUOut_M,
   input  logic [31:0] WriteData_M,
   input  logic [31:0] pc_M,
   output logic [31:0] ReadData_M,
   output logic        AddrErr_M
);

   localparam int unsigned DEPTH       = 1 << ADDR_WIDTH;
   localparam logic [32:0] RANGE_BYTES = 33'd4 << ADDR_WIDTH;

   logic [31:0]           mem [0:DEPTH-1];
   logic [31:0]           off;
   logic [ADDR_WIDTH-1:0] idx;
   logic                  in_range;
   logic                  misaligned;
   logic                  rsvd_size;
   logic [31:0]           old_word;
   logic [31:0]           merged;
   logic [3:0]            byte_mask;
   logic                  commit;

   // Addresses below BASE_ADDR wrap to large offsets and fail the range test;
   // the extra bit keeps the compare safe when 4*DEPTH reaches 2^32.
   assign off      = ALUOut_M - BASE_ADDR;
   assign idx      = off[ADDR_WIDTH+1:2];
   assign in_range = {1'b0, off} < RANGE_BYTES;

   always_comb begin
      misaligned = 1'b0;
      rsvd_size  = 1'b0;
      case (size_e'(Size_M))
         SZ_WORD: misaligned = (off[1:0] != 2'b00);
         SZ_HALF: misaligned = off[0];
         SZ_BYTE: misaligned = 1'b0;
         default: rsvd_size  = 1'b1;
      endcase
   end

   assign AddrErr_M  = (MemWrite_M | MemRead_M) & (misaligned | ~in_range | rsvd_size);
   assign old_word   = mem[idx];
   assign ReadData_M = in_range ? old_word : '0;

   dm_store_merge u_store_merge (
      .old_word  (old_word),
      .wdata     (WriteData_M),
      .size      (Size_M),
      .lane      (off[1:0]),
      .merged    (merged),
      .byte_mask (byte_mask)
   );

   assign commit = MemWrite_M & ~AddrErr_M & (|byte_mask);

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (commit) begin
         mem[idx] <= merged;
      end
   end

`ifdef DM_DISPLAY_EN
   always_ff @(posedge clk) begin
      if (!reset && commit)
         $display("%d@%h: *%h <= %h", $time, pc_M, BASE_ADDR + (32'(idx) << 2), merged);
   end
`else
   logic unused_pc;
   assign unused_pc = ^pc_M;
`endif

endmodule

// File: tb/tb_dm_stage.sv
module tb_dm_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemWrite_M;
   logic        MemRead_M;
   logic [1:0]  Size_M;
   logic [31:0] ALUOut_M;
   logic [31:0] WriteData_M;
   logic [31:0] pc_M;
   logic [31:0] ReadData_M;
   logic        AddrErr_M;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   typedef struct {
      string       tag;
      logic [31:0] rd;
      logic        err;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] mdl [0:1023];

   dm_stage #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0000_0000)) dut (
      .clk         (clk),
      .reset       (reset),
      .MemWrite_M  (MemWrite_M),
      .MemRead_M   (MemRead_M),
      .Size_M      (Size_M),
      .ALUOut_M    (ALUOut_M),
      .WriteData_M (WriteData_M),
      .pc_M        (pc_M),
      .ReadData_M  (ReadData_M),
      .AddrErr_M   (AddrErr_M)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: 4 KiB at base 0.
   function automatic logic model_err(input logic we, input logic re, input logic [1:0] sz,
                                      input logic [31:0] a);
      logic bad;
      bad = (a >= 32'h1000);
      if (sz == 2'b11) bad = 1'b1;
      if (sz == 2'b00 && a[1:0] != 2'b00) bad = 1'b1;
      if (sz == 2'b01 && a[0]) bad = 1'b1;
      return (we | re) & bad;
   endfunction

   task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
      logic [31:0] w;
      w = mdl[a[11:2]];
      case (sz)
         2'b00: w = wd;
         2'b01: if (a[1]) w[31:16] = wd[15:0]; else w[15:0] = wd[15:0];
         2'b10: w[8*a[1:0] +: 8] = wd[7:0];
         default: ;
      endcase
      mdl[a[11:2]] = w;
   endtask

   // One pipeline cycle: drive, push expectation, sample at negedge, then
   // update the model for the commit at the following posedge.
   task automatic do_op(input string tag, input logic we, input logic re,
                        input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
      exp_t e;
      exp_t g;
      @(posedge clk); #1;
      MemWrite_M  = we;
      MemRead_M   = re;
      Size_M      = sz;
      ALUOut_M    = a;
      WriteData_M = wd;
      pc_M        = pc_M + 32'd4;
      e.tag = tag;
      e.err = model_err(we, re, sz, a);
      e.rd  = (a < 32'h1000) ? mdl[a[11:2]] : 32'h0;
      sb_q.push_back(e);
      @(negedge clk);
      if (sb_q.size() == 0) begin
         check({tag, "_queue_empty"}, 32'd1, 32'd0);
      end else begin
         g = sb_q.pop_front();
         check({g.tag, "_rd"},  ReadData_M, g.rd);
         check({g.tag, "_err"}, {31'd0, AddrErr_M}, {31'd0, g.err});
      end
      if (we && !e.err) model_store(sz, a, wd);
   endtask

   task automatic idle();
      MemWrite_M  = 1'b0;
      MemRead_M   = 1'b0;
      Size_M      = 2'b00;
      ALUOut_M    = '0;
      WriteData_M = '0;
   endtask

   // One reset cycle carrying a store that must be dropped.
   task automatic pulse_reset(input logic [31:0] a, input logic [31:0] wd);
      @(posedge clk); #1;
      reset       = 1'b1;
      MemWrite_M  = 1'b1;
      MemRead_M   = 1'b0;
      Size_M      = 2'b00;
      ALUOut_M    = a;
      WriteData_M = wd;
      @(posedge clk); #1;
      reset = 1'b0;
      idle();
      for (int i = 0; i < 1024; i++) mdl[i] = '0;
   endtask

   initial begin
      logic [31:0] a;
      logic [1:0]  sz;
      pc_M  = 32'h0000_1000;
      reset = 1'b1;
      idle();
      for (int i = 0; i < 1024; i++) mdl[i] = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // Post-reset reads and idle error flag
      do_op("rst_idx0",    1'b0, 1'b1, 2'b00, 32'h0000_0000, '0);
      do_op("rst_idx5",    1'b0, 1'b1, 2'b00, 32'h0000_0014, '0);
      do_op("rst_idx1023", 1'b0, 1'b1, 2'b00, 32'h0000_0FFC, '0);
      do_op("no_req",      1'b0, 1'b0, 2'b11, 32'h0000_0013, '0);

      // Word store then sub-word merges on consecutive cycles
      do_op("sw_10",  1'b1, 1'b0, 2'b00, 32'h0000_0010, 32'hDEADBEEF);
      do_op("rd_10a", 1'b0, 1'b1, 2'b00, 32'h0000_0010, '0);
      check("const_deadbeef", ReadData_M, 32'hDEADBEEF);
      do_op("sb_12",  1'b1, 1'b0, 2'b10, 32'h0000_0012, 32'hFFFF_FF11);
      do_op("sh_10",  1'b1, 1'b0, 2'b01, 32'h0000_0010, 32'hFFFF_2233);
      do_op("rd_10b", 1'b0, 1'b1, 2'b00, 32'h0000_0010, '0);
      check("const_de112233", ReadData_M, 32'hDE112233);

      // Erroring stores leave memory unchanged
      do_op("sw_mis",  1'b1, 1'b0, 2'b00, 32'h0000_0012, 32'h1234_5678);
      do_op("sh_mis",  1'b1, 1'b0, 2'b01, 32'h0000_0011, 32'h0000_9999);
      do_op("sz_rsvd", 1'b1, 1'b0, 2'b11, 32'h0000_0020, 32'hAAAA_AAAA);
      do_op("rd_10c",  1'b0, 1'b1, 2'b00, 32'h0000_0010, '0);
      check("const_unchanged", ReadData_M, 32'hDE112233);
      do_op("rd_20",   1'b0, 1'b1, 2'b00, 32'h0000_0020, '0);

      // Out of range: no wrap into idx 0
      do_op("sw_oor",   1'b1, 1'b0, 2'b00, 32'h0000_1000, 32'hCAFE_F00D);
      do_op("rd_1000",  1'b0, 1'b1, 2'b00, 32'h0000_1000, '0);
      do_op("rd_0",     1'b0, 1'b1, 2'b00, 32'h0000_0000, '0);
      do_op("rd_below", 1'b0, 1'b1, 2'b00, 32'hFFFF_FFFC, '0);
      do_op("sb_last",  1'b1, 1'b0, 2'b10, 32'h0000_0FFF, 32'h0000_00A5);
      do_op("rd_ffc",   1'b0, 1'b1, 2'b00, 32'h0000_0FFC, '0);

      // Same-cycle store and load: old value first, new value next cycle
      do_op("sw_rd_40", 1'b1, 1'b1, 2'b00, 32'h0000_0040, 32'h0000_0001);
      check("const_old_40", ReadData_M, 32'h0);
      do_op("rd_40",    1'b0, 1'b1, 2'b00, 32'h0000_0040, '0);
      check("const_new_40", ReadData_M, 32'h1);

      // Random sub-word traffic over a small window
      for (int i = 0; i < 40; i++) begin
         sz = 2'($urandom_range(0, 3));
         a  = 32'($urandom_range(0, 63));
         if (i % 10 == 9) a = 32'h0000_1000 + a;
         do_op("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sz, a, $urandom);
      end

      // Reset right after a store cycle clears everything
      do_op("sw_44", 1'b1, 1'b0, 2'b00, 32'h0000_0044, 32'h7777_7777);
      pulse_reset(32'h0000_0040, 32'h0000_0005);
      do_op("rst_rd_40", 1'b0, 1'b1, 2'b00, 32'h0000_0040, '0);
      check("const_rst_40", ReadData_M, 32'h0);
      do_op("rst_rd_44", 1'b0, 1'b1, 2'b00, 32'h0000_0044, '0);
      do_op("rst_rd_10", 1'b0, 1'b1, 2'b00, 32'h0000_0010, '0);

      @(posedge clk); #1;
      idle();
      check("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
